// File: rtl/xvc_buf_pkg.sv
// Shared types and default geometry for the receive-side packet buffer.
package xvc_buf_pkg;
  localparam int DEFAULT_DATA_W     = 8;
  localparam int DEFAULT_SLOTS      = 4;
  localparam int DEFAULT_SLOT_DEPTH = 16;

  localparam int SLOT_IDX_W = $clog2(DEFAULT_SLOTS);
  localparam int ELEM_IDX_W = $clog2(DEFAULT_SLOT_DEPTH);
  localparam int LEN_W      = ELEM_IDX_W + 1;
  localparam int COUNT_W    = SLOT_IDX_W + 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_FILL  = 2'd1,
    RX_DRAIN = 2'd2
  } rx_state_t;

  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;
  typedef logic [ELEM_IDX_W-1:0] elem_idx_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             ovf;
  } slot_desc_t;
endpackage

// File: rtl/packet_slot_ram.sv
// Simple dual-port slot memory: one write port, one registered read port.
module packet_slot_ram #(
  parameter int DATA_W     = 8,
  parameter int SLOTS      = 4,
  parameter int SLOT_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [$clog2(SLOTS)-1:0]      wr_slot,
  input  logic [$clog2(SLOT_DEPTH)-1:0] wr_idx,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [$clog2(SLOTS)-1:0]      rd_slot,
  input  logic [$clog2(SLOT_DEPTH)-1:0] rd_idx,
  output logic [DATA_W-1:0]             rd_data
);
  logic [DATA_W-1:0] mem [SLOTS*SLOT_DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (we) mem[{wr_slot, wr_idx}] <= wr_data;
  end

  always_comb rd_data_d = mem[{rd_slot, rd_idx}];

  // Only the output register is cleared; array contents are left alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/packet_fifo_in.sv
// Receive packet buffer: frames an element stream into slots and presents
// the oldest committed packet for random-access reads until it is popped.
module packet_fifo_in
  import xvc_buf_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int SLOTS      = DEFAULT_SLOTS,
  parameter int SLOT_DEPTH = DEFAULT_SLOT_DEPTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               rx_data,
  input  logic                            rx_valid,
  input  logic                            rx_last,
  output logic                            rx_ready,
  output logic                            rd_avail,
  output logic [$clog2(SLOT_DEPTH):0]     rd_len,
  output logic                            rd_ovf,
  input  logic [$clog2(SLOT_DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]               rd_data,
  input  logic                            rd_pop,
  output logic [$clog2(SLOTS):0]          pkt_count
);
  localparam int SW = $clog2(SLOTS);
  localparam int IW = $clog2(SLOT_DEPTH);
  localparam int LW = IW + 1;
  localparam int CW = SW + 1;
  localparam logic [LW-1:0] FULL_LEN = LW'(SLOT_DEPTH);
  localparam logic [CW-1:0] MAX_CNT  = CW'(SLOTS);

  typedef struct packed {
    logic [LW-1:0] len;
    logic          ovf;
  } desc_t;

  rx_state_t     state_q, state_d;
  logic [LW-1:0] fill_q, fill_d;
  logic          ovf_q, ovf_d;
  logic [SW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rx_ready_q, rx_ready_d;
  desc_t         desc_q [SLOTS];
  desc_t         desc_d [SLOTS];

  logic          accept, pop, commit, we;
  logic [IW-1:0] wr_idx;

  always_comb begin
    accept  = rx_valid && rx_ready_q;
    pop     = rd_pop && (cnt_q != '0);
    state_d = state_q;
    fill_d  = fill_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    wr_idx  = fill_q[IW-1:0];
    commit  = 1'b0;
    if (accept) begin
      unique case (state_q)
        RX_IDLE: begin
          we     = 1'b1;
          wr_idx = '0;
          fill_d = LW'(1);
          ovf_d  = 1'b0;
          if (rx_last) commit = 1'b1;
          else         state_d = RX_FILL;
        end
        RX_FILL: begin
          if (fill_q == FULL_LEN) begin
            ovf_d   = 1'b1;
            state_d = RX_DRAIN;
          end else begin
            we     = 1'b1;
            fill_d = fill_q + LW'(1);
          end
          if (rx_last) begin
            commit  = 1'b1;
            state_d = RX_IDLE;
          end
        end
        RX_DRAIN: begin
          if (rx_last) begin
            commit  = 1'b1;
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    wr_ptr_d = commit ? wr_ptr_q + SW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + SW'(1) : rd_ptr_q;
    unique case ({commit, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Ready is registered, so it is derived from the post-edge state and count.
    rx_ready_d = (state_d == RX_IDLE) ? (cnt_d < MAX_CNT) : 1'b1;

    for (int i = 0; i < SLOTS; i++) desc_d[i] = desc_q[i];
    if (commit) desc_d[wr_ptr_q] = '{len: fill_d, ovf: ovf_d};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      fill_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rx_ready_q <= 1'b0;
      for (int i = 0; i < SLOTS; i++) desc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rx_ready_q <= rx_ready_d;
      for (int i = 0; i < SLOTS; i++) desc_q[i] <= desc_d[i];
    end
  end

  packet_slot_ram #(
    .DATA_W     (DATA_W),
    .SLOTS      (SLOTS),
    .SLOT_DEPTH (SLOT_DEPTH)
  ) u_ram (
    .clk     (clock),
    .rst_n   (reset),
    .we      (we),
    .wr_slot (wr_ptr_q),
    .wr_idx  (wr_idx),
    .wr_data (rx_data),
    .rd_slot (rd_ptr_q),
    .rd_idx  (rd_addr),
    .rd_data (rd_data)
  );

  assign rx_ready  = rx_ready_q;
  assign rd_avail  = (cnt_q != '0);
  assign rd_len    = desc_q[rd_ptr_q].len;
  assign rd_ovf    = desc_q[rd_ptr_q].ovf;
  assign pkt_count = cnt_q;
endmodule

// File: doc/packet_fifo_in.md
Name: packet_fifo_in

Overview:
- Receive-side packet buffer: the counterpart of the outbound packet FIFO.
- Accepts a byte stream from the network/XVC front end and frames it into packets using a last-beat marker.
- Stores up to SLOTS complete packets in slot memory.
- Presents the oldest committed packet to the command decoder for random-access reads (length plus indexed bytes) until the decoder releases it.

Parameters:
- DATA_W, 8, width of one stored element.
- SLOTS, 4, number of packet slots (power of two, ≥2).
- SLOT_DEPTH, 16, maximum elements per packet (power of two).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  DATA_W  incoming element.
- rx_valid  in  1  rx_data valid this cycle.
- rx_last  in  1  rx_data is the final element of the packet.
- rx_ready  out  1  block accepts the element this cycle.
- rd_avail  out  1  a committed packet is presented at the head.
- rd_len  out  $clog2(SLOT_DEPTH)+1  element count of the head packet.
- rd_ovf  out  1  head packet was truncated.
- rd_addr  in  $clog2(SLOT_DEPTH)  element index to read in the head packet.
- rd_data  out  DATA_W  head[rd_addr], registered.
- rd_pop  in  1  release the head packet (1-cycle pulse).
- pkt_count  out  $clog2(SLOTS)+1  committed packets held.

Behaviour:
- Reset (reset=0, async):
  - rx_ready=0, rd_avail=0, rd_len=0, rd_ovf=0, rd_data=0, pkt_count=0.
  - Write and read slot pointers = 0; RX FSM = RX_IDLE.
  - Reset mid-packet discards every partial and committed packet. Memory contents are don't-care.
- Accept rule: an element is accepted when rx_valid && rx_ready at the clock edge.
- RX FSM:
  - RX_IDLE:
    - rx_ready = (pkt_count < SLOTS).
    - On an accepted element: store it at index 0 of the write slot, set fill=1.
    - If rx_last: commit immediately, stay in RX_IDLE. Otherwise go to RX_FILL.
  - RX_FILL:
    - rx_ready=1.
    - If fill < SLOT_DEPTH: store the element at index fill, then fill++.
    - If fill == SLOT_DEPTH: discard the element, set the slot's ovf flag, go to RX_DRAIN.
    - On an accepted rx_last: commit, go to RX_IDLE.
  - RX_DRAIN:
    - rx_ready=1; all elements are discarded.
    - On an accepted rx_last: commit with len=SLOT_DEPTH and ovf=1, go to RX_IDLE.
- Commit:
  - Writes the slot len and ovf registers.
  - Advances the write slot pointer, modulo SLOTS wrap.
  - Increments pkt_count.
  - The packet becomes visible (rd_avail=1, rd_len valid) on the cycle after the last-element edge.
- Back-pressure:
  - A new packet waits in RX_IDLE with rx_ready=0 while all SLOTS are committed.
  - Once a packet has started, its slot is already reserved, so it never stalls.
- Read side:
  - rd_avail = (pkt_count != 0).
  - rd_len and rd_ovf reflect the slot at the read pointer.
  - rd_data is updated one cycle after rd_addr: synchronous RAM read of head slot at rd_addr.
  - rd_addr ≥ rd_len returns stale slot contents; this is legal, not an error.
- Pop:
  - rd_pop while rd_avail advances the read pointer (modulo wrap) and decrements pkt_count.
  - rd_pop while !rd_avail is ignored.
  - After a pop, the next packet's rd_len is valid on the following cycle. rd_data for the new head is valid one cycle after the first rd_addr presented post-pop.
- Simultaneous commit and pop: pkt_count is unchanged and both pointers advance. A commit into the slot freed by the same-cycle pop is not possible, because rx_ready was computed from the pre-pop count.
- Write/read independence: a write to slot W never corrupts reads of head slot R≠W (dual-port memory).

Decomposition:
- Package xvc_buf_pkg holds:
  - DATA_W, SLOTS and SLOT_DEPTH defaults.
  - The rx_state_t enum (RX_IDLE, RX_FILL, RX_DRAIN).
  - Slot-index and element-index typedefs.
  - A slot-descriptor struct {len, ovf}.
- One sub-module, packet_slot_ram:
  - Simple dual-port RAM of SLOTS*SLOT_DEPTH x DATA_W.
  - Write port {slot, idx, data, we}; synchronous read port {slot, idx} giving data.
- Top level holds the FSM, pointers, counters and the descriptor registers.

Test Plan:
- Single packet: send 100..107 with rx_last on 107, then idle 1 cycle → rd_avail=1, rd_len=8, rd_ovf=0; rd_addr=0..7 → rd_data=100..107 one cycle later each.
- Two queued packets: send 100..107 then 200..203 → pkt_count=2 with head len 8; rd_pop → pkt_count=1, rd_len=4, reads give 200..203; second pop → rd_avail=0.
- Full back-pressure: send 4 single-element packets 1,2,3,4 (SLOTS=4) → rx_ready=0, pkt_count=4. Hold rx_valid with 5 → not accepted until an rd_pop; the next cycle rx_ready=1, and head rd_data@0 becomes 2.
- Overflow: send 20 elements 0..19 with last on 19 → rd_len=16, rd_ovf=1, reads 0..15; the next packet 50 (last) is stored normally with len=1.
- Simultaneous commit and pop, plus wrap: with 3 packets held, pop on the same edge as another packet's last → pkt_count stays 3. Cycle through 6 packets → pointer wrap, order preserved.
- Async reset mid-packet: after 3 elements of a packet, pulse reset low for 7 ns between edges → outputs zero immediately. After release, a fresh packet 9,8 gives rd_len=2, rd_data 9,8.
